// File: rtl/contador_ctrl_pkg.sv
// Shared constants for the counter blocks: count width, default terminal
// count, FSM state encoding and the count reload rule.
package contador_ctrl_pkg;

  localparam int COUNT_W           = 8;
  localparam int MAX_COUNT_DEFAULT = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Counting up restarts from zero; counting down restarts from the terminal value.
  function automatic logic [COUNT_W-1:0] load_value(input logic                dir,
                                                    input logic [COUNT_W-1:0] max_count);
    return dir ? max_count : '0;
  endfunction

endpackage

// File: rtl/tiempo_tick.sv
// Clock-enable prescaler: while en is high, emits a one-cycle tick every DIV
// clk cycles; held at zero whenever en is low.
module tiempo_tick #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (!en || r_cnt == LAST) r_cnt <= '0;
    else                           r_cnt <= r_cnt + W'(1);
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/contador_ctrl.sv
// Start/stop/clear controlled up/down counter advancing on prescaler ticks,
// with optional wrap or stop-in-DONE at the terminal count.
module contador_ctrl
  import contador_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_DEFAULT,
  parameter int DIV       = 50_000_000,
  parameter bit WRAP      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         btn_clear,
  input  logic         dir,
  output logic [7:0]   count,
  output logic         running,
  output logic         tc_pulse,
  output logic [1:0]   state
);

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               w_tick;
  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic               r_running;
  logic               r_tc;

  // NOTE: reset asserts asynchronously but releases two edges later in step
  // with clk, so no flop sees deassertion close to an active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  tiempo_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (w_rst_n),
    .en    (r_state == ST_RUN),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_running <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (btn_clear) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_count   <= load_value(dir, MAX_C);
      end else begin
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            if (btn_start && !btn_stop) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (btn_stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_tick) begin
              // Anything at or beyond MAX_C counts as terminal when counting up.
              if ((!dir && r_count >= MAX_C) || (dir && r_count == '0)) begin
                r_tc <= 1'b1;
                if (WRAP) begin
                  r_count <= load_value(dir, MAX_C);
                end else begin
                  r_state   <= ST_DONE;
                  r_running <= 1'b0;
                end
              end else if (!dir) begin
                r_count <= r_count + COUNT_W'(1);
              end else begin
                r_count <= r_count - COUNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            if (btn_start && !btn_stop) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_count   <= load_value(dir, MAX_C);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count    = r_count;
  assign running  = r_running;
  assign tc_pulse = r_tc;
  assign state    = r_state;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl (DIV=4, MAX_COUNT=25): one wrapping and one
// stop-in-DONE instance share the same command inputs.
module tb_contador_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0, dir = 1'b0;
  logic [7:0] w_count, n_count;
  logic       w_running, n_running, w_tc, n_tc;
  logic [1:0] w_state, n_state;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  contador_ctrl #(.MAX_COUNT(25), .DIV(4), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_clear(btn_clear), .dir(dir), .count(w_count), .running(w_running),
    .tc_pulse(w_tc), .state(w_state)
  );

  contador_ctrl #(.MAX_COUNT(25), .DIV(4), .WRAP(1'b0)) dut_nowrap (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_clear(btn_clear), .dir(dir), .count(n_count), .running(n_running),
    .tc_pulse(n_tc), .state(n_state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic p, input logic c);
    btn_start = s; btn_stop = p; btn_clear = c;
    step(1);
    btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    total++; if ({w_count, w_state, w_running, w_tc} !== 12'h000) begin
      bad++; $display("FAIL reset_wrap got=%h exp=000", {w_count, w_state, w_running, w_tc}); end
    total++; if ({n_count, n_state, n_running, n_tc} !== 12'h000) begin
      bad++; $display("FAIL reset_nowrap got=%h exp=000", {n_count, n_state, n_running, n_tc}); end
    rst_n = 1'b1;
    step(3);
    total++; if (w_state !== 2'b00 || w_count !== 8'd0) begin
      bad++; $display("FAIL reset_release state=%0d count=%0d exp 0/0", w_state, w_count); end
  endtask

  task automatic test_wrap_up;
    dir = 1'b0;
    press(0, 0, 1);
    press(1, 0, 0);
    total++; if (w_state !== 2'b01 || w_running !== 1'b1 || w_count !== 8'd0) begin
      bad++; $display("FAIL up_start state=%0d run=%0d count=%0d exp 1/1/0", w_state, w_running, w_count); end
    for (int i = 1; i <= 26; i++) begin
      step(3);
      total++; if (w_count !== 8'((i - 1) % 26) || w_tc !== 1'b0) begin
        bad++; $display("FAIL up_hold[%0d] count=%0d tc=%0d exp %0d/0", i, w_count, w_tc, (i - 1) % 26); end
      step(1);
      total++; if (w_count !== 8'(i % 26) || w_tc !== (i == 26)) begin
        bad++; $display("FAIL up_tick[%0d] count=%0d tc=%0d exp %0d/%0d", i, w_count, w_tc, i % 26, i == 26); end
    end
    total++; if (n_state !== 2'b11 || n_count !== 8'd25 || n_tc !== 1'b1 || n_running !== 1'b0) begin
      bad++; $display("FAIL up_nowrap_done state=%0d count=%0d tc=%0d run=%0d exp 3/25/1/0",
                      n_state, n_count, n_tc, n_running); end
    step(1);
    total++; if (w_tc !== 1'b0 || n_tc !== 1'b0 || w_state !== 2'b01) begin
      bad++; $display("FAIL up_tc_width w_tc=%0d n_tc=%0d w_state=%0d exp 0/0/1", w_tc, n_tc, w_state); end
  endtask

  task automatic test_nowrap_down;
    dir = 1'b1;
    press(0, 0, 1);
    total++; if (n_count !== 8'd25 || n_state !== 2'b00) begin
      bad++; $display("FAIL down_clear count=%0d state=%0d exp 25/0", n_count, n_state); end
    press(1, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      step(4);
      total++; if (n_count !== 8'(25 - i) || n_tc !== 1'b0) begin
        bad++; $display("FAIL down_tick[%0d] count=%0d tc=%0d exp %0d/0", i, n_count, n_tc, 25 - i); end
    end
    step(4);
    total++; if (n_tc !== 1'b1 || n_state !== 2'b11 || n_count !== 8'd0 || n_running !== 1'b0) begin
      bad++; $display("FAIL down_done tc=%0d state=%0d count=%0d run=%0d exp 1/3/0/0",
                      n_tc, n_state, n_count, n_running); end
    total++; if (w_tc !== 1'b1 || w_count !== 8'd25 || w_state !== 2'b01) begin
      bad++; $display("FAIL down_wrap tc=%0d count=%0d state=%0d exp 1/25/1", w_tc, w_count, w_state); end
    step(4);
    total++; if (n_state !== 2'b11 || n_count !== 8'd0 || n_tc !== 1'b0) begin
      bad++; $display("FAIL down_done_hold state=%0d count=%0d tc=%0d exp 3/0/0", n_state, n_count, n_tc); end
    press(1, 0, 0);
    total++; if (n_state !== 2'b01 || n_count !== 8'd25 || n_tc !== 1'b0) begin
      bad++; $display("FAIL done_reload state=%0d count=%0d tc=%0d exp 1/25/0", n_state, n_count, n_tc); end
    step(1);
    total++; if (n_tc !== 1'b0 || n_count !== 8'd25) begin
      bad++; $display("FAIL done_reload_tc tc=%0d count=%0d exp 0/25", n_tc, n_count); end
  endtask

  task automatic test_stop_tick;
    dir = 1'b0;
    press(0, 0, 1);
    press(1, 0, 0);
    step(28);
    total++; if (w_count !== 8'd7) begin
      bad++; $display("FAIL stop_pre count=%0d exp 7", w_count); end
    step(3);
    press(0, 1, 0);
    total++; if (w_count !== 8'd7 || w_state !== 2'b10 || w_running !== 1'b0) begin
      bad++; $display("FAIL stop_tick count=%0d state=%0d run=%0d exp 7/2/0", w_count, w_state, w_running); end
    step(5);
    total++; if (w_count !== 8'd7 || w_state !== 2'b10) begin
      bad++; $display("FAIL pause_hold count=%0d state=%0d exp 7/2", w_count, w_state); end
    press(1, 0, 0);
    step(3);
    total++; if (w_count !== 8'd7 || w_state !== 2'b01) begin
      bad++; $display("FAIL resume_wait count=%0d state=%0d exp 7/1", w_count, w_state); end
    step(1);
    total++; if (w_count !== 8'd8) begin
      bad++; $display("FAIL resume_tick count=%0d exp 8", w_count); end
  endtask

  task automatic test_clear_priority;
    dir = 1'b0;
    press(0, 0, 1);
    press(1, 0, 0);
    step(48);
    total++; if (w_count !== 8'd12) begin
      bad++; $display("FAIL prio_pre count=%0d exp 12", w_count); end
    press(1, 1, 1);
    total++; if ({w_state, w_count, w_running, w_tc} !== 12'h000) begin
      bad++; $display("FAIL prio_wrap got=%h exp=000", {w_state, w_count, w_running, w_tc}); end
    total++; if ({n_state, n_count, n_running} !== 11'h000) begin
      bad++; $display("FAIL prio_nowrap got=%h exp=000", {n_state, n_count, n_running}); end
  endtask

  task automatic test_dir_toggle;
    int exp_seq[4] = '{2, 1, 0, 25};
    dir = 1'b0;
    press(0, 0, 1);
    press(1, 0, 0);
    step(12);
    total++; if (w_count !== 8'd3) begin
      bad++; $display("FAIL toggle_pre count=%0d exp 3", w_count); end
    dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(4);
      total++; if (w_count !== 8'(exp_seq[k]) || w_tc !== (k == 3) || w_state !== 2'b01) begin
        bad++; $display("FAIL toggle[%0d] count=%0d tc=%0d state=%0d exp %0d/%0d/1",
                        k, w_count, w_tc, w_state, exp_seq[k], k == 3); end
    end
  endtask

  task automatic test_async_reset;
    dir = 1'b0;
    press(0, 0, 1);
    press(1, 0, 0);
    step(72);
    total++; if (w_count !== 8'd18 || w_state !== 2'b01) begin
      bad++; $display("FAIL areset_pre count=%0d state=%0d exp 18/1", w_count, w_state); end
    step(2);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({w_count, w_state, w_running, w_tc} !== 12'h000) begin
      bad++; $display("FAIL areset_wrap got=%h exp=000", {w_count, w_state, w_running, w_tc}); end
    total++; if ({n_count, n_state, n_running, n_tc} !== 12'h000) begin
      bad++; $display("FAIL areset_nowrap got=%h exp=000", {n_count, n_state, n_running, n_tc}); end
    step(2);
    total++; if (w_tc !== 1'b0 || w_state !== 2'b00 || w_count !== 8'd0) begin
      bad++; $display("FAIL areset_hold tc=%0d state=%0d count=%0d exp 0/0/0", w_tc, w_state, w_count); end
    rst_n = 1'b1;
    step(3);
    total++; if (w_state !== 2'b00 || w_count !== 8'd0 || w_running !== 1'b0) begin
      bad++; $display("FAIL areset_release state=%0d count=%0d run=%0d exp 0/0/0", w_state, w_count, w_running); end
    press(1, 0, 0);
    total++; if (w_state !== 2'b01 || w_running !== 1'b1) begin
      bad++; $display("FAIL areset_restart state=%0d run=%0d exp 1/1", w_state, w_running); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_nowrap_down();
    test_stop_tick();
    test_clear_priority();
    test_dir_toggle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
CONTADOR_CTRL -- requirements
Module: contador_ctrl

Interface
REQ-001 Parameter MAX_COUNT, default 25, terminal count value; legal range 1..255.
REQ-002 Parameter DIV, default 50_000_000, clk cycles per count tick; legal range ≥ 2.
REQ-003 Parameter WRAP, default 1: 1 = wrap at terminal count and keep running; 0 = stop in DONE.
REQ-004 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: btn_start  input  1  start/resume command; single-cycle pulse, already synchronous to clk.
REQ-007 Port: btn_stop  input  1  pause command; single-cycle pulse.
REQ-008 Port: btn_clear  input  1  clear command; single-cycle pulse.
REQ-009 Port: dir  input  1  count direction: 0 = up, 1 = down; sampled on every tick.
REQ-010 Port: count  output  8  current count value.
REQ-011 Port: running  output  1  high exactly while state = RUN.
REQ-012 Port: tc_pulse  output  1  one-cycle pulse on a terminal-count event.
REQ-013 Port: state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-014 The block SHALL run entirely on clk; no derived or gated clocks. The count advances only on a one-cycle tick enable.
REQ-015 Prescaler SHALL count 0..DIV-1 only while state = RUN, and SHALL assert tick on the cycle it equals DIV-1, then return to 0.
REQ-016 Prescaler SHALL be forced to 0 in every state other than RUN, so the first tick arrives exactly DIV cycles after entering RUN.
REQ-017 Command priority SHALL be clear > stop > start when commands coincide in the same cycle.
REQ-018 IDLE: btn_start -> RUN; all other commands have no effect except clear.
REQ-019 RUN: btn_stop -> PAUSE; a tick in the same cycle is discarded and count holds.
REQ-020 PAUSE: btn_start -> RUN; count holds. Prescaler restarts from 0.
REQ-021 DONE: btn_start -> RUN with count reloaded (0 if dir=0, MAX_COUNT if dir=1); tc_pulse is not asserted on this reload.
REQ-022 btn_clear in any state -> IDLE, with count loaded to 0 if dir=0 and to MAX_COUNT if dir=1; a same-cycle tick is discarded.
REQ-023 Up tick: count < MAX_COUNT -> count+1. Count > MAX_COUNT is also treated as terminal.
REQ-024 Up tick at terminal: WRAP=1 -> count=0, tc_pulse=1, stay in RUN; WRAP=0 -> count holds, tc_pulse=1, go to DONE.
REQ-025 Down tick: count > 0 -> count-1.
REQ-026 Down tick at count=0: WRAP=1 -> count=MAX_COUNT, tc_pulse=1; WRAP=0 -> count holds at 0, tc_pulse=1, go to DONE.
REQ-027 A change of dir mid-run SHALL take effect on the next tick, with no glitch or skipped value.
REQ-028 count, state and running SHALL be registered outputs. tc_pulse SHALL be registered and assert the same cycle count takes its post-tick value.

Reset
REQ-029 While rst_n = 0: state=IDLE, count=0, running=0, tc_pulse=0, prescaler=0, applied asynchronously.
REQ-030 Reset SHALL be released synchronously internally, so the first active edge after deassertion behaves as a normal IDLE cycle.
REQ-031 Reset asserted mid-RUN SHALL abort immediately with no tc_pulse.

Structure
REQ-032 State encodings and the default MAX_COUNT SHALL be defined once in the shared project constants include, alongside the other counter blocks.
REQ-033 The prescaler SHALL be a separate sub-module, tiempo_tick (parameters DIV; ports clk, rst_n, en, tick), replacing derived-clock dividers.
REQ-034 The FSM and count datapath SHALL reside in contador_ctrl.

Verification (DIV=4, MAX_COUNT=25)
REQ-035 Reset, then start with dir=0 and WRAP=1, run 26 ticks -> count goes 0..25 then 0; one tc_pulse on the 25->0 tick; ticks every 4 cycles.
REQ-036 WRAP=0, dir=1, clear then start -> count goes 25..0; next tick gives tc_pulse and state=DONE with count=0; start reloads 25 without tc_pulse.
REQ-037 Stop coincident with a tick at count=7 -> count stays 7, state=PAUSE; start -> first increment to 8 exactly 4 cycles later.
REQ-038 start+stop+clear in the same cycle while in RUN at count=12 -> state=IDLE, count=0, running=0.
REQ-039 Toggle dir at count=3 while running up -> next ticks give 2, 1, 0, then 25 with tc_pulse (WRAP=1).
REQ-040 Assert rst_n=0 mid-RUN at count=18 -> all outputs reset within the same cycle (asynchronous); no tc_pulse; IDLE after release.
